// File: rtl/sum_window_pkg.sv
// Sizing helpers and result layout shared by the sum window accumulator.
// The max field exists only when SUM_WIN_MAX_EN is defined.
package sum_window_pkg;

    function automatic int acc_width(input int sum_w, input int log2_n);
        return sum_w + log2_n;
    endfunction

    function automatic int win_count(input int log2_n);
        return 1 << log2_n;
    endfunction

    localparam int SUM_W_DEF  = 9;
    localparam int LOG2_N_DEF = 3;
    localparam int ACC_W_DEF  = acc_width(SUM_W_DEF, LOG2_N_DEF);

    typedef struct packed {
        logic [ACC_W_DEF-1:0] acc;
        logic [SUM_W_DEF-1:0] avg;
`ifdef SUM_WIN_MAX_EN
        logic [SUM_W_DEF-1:0] max;
`endif
    } win_result_t;

endpackage

// File: rtl/sum_win_outreg.sv
// One-entry valid/ready holding register that can reload on the same edge it drains.
module sum_win_outreg
    import sum_window_pkg::*;
#(
    parameter type data_t = win_result_t
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  data_t load_data,
    input  logic  out_rdy,
    output logic  out_vld,
    output data_t out_data
);

    // The producer only loads when the slot is empty or draining this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_data <= '0;
        end else if (load) begin
            out_vld  <= 1'b1;
            out_data <= load_data;
        end else if (out_vld && out_rdy) begin
            out_vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/sum_window_acc.sv
// Accumulates windows of 2**LOG2_N sums and presents total/average on a valid/ready output.
// Define SUM_WIN_MAX_EN to add the per-window maximum output win_max.
module sum_window_acc
    import sum_window_pkg::*;
#(
    parameter  int SUM_W  = 9,
    parameter  int LOG2_N = 3,
    localparam int ACC_W  = acc_width(SUM_W, LOG2_N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [SUM_W-1:0] sum_i,
    input  logic             sum_vld,
    output logic             sum_rdy,
    output logic             win_vld,
    input  logic             win_rdy,
    output logic [ACC_W-1:0] win_acc,
    output logic [SUM_W-1:0] win_avg
`ifdef SUM_WIN_MAX_EN
    ,
    output logic [SUM_W-1:0] win_max
`endif
);

    localparam int                N    = win_count(LOG2_N);
    localparam logic [LOG2_N-1:0] LAST = LOG2_N'(N - 1);

    typedef struct packed {
        logic [ACC_W-1:0] acc;
        logic [SUM_W-1:0] avg;
`ifdef SUM_WIN_MAX_EN
        logic [SUM_W-1:0] max;
`endif
    } result_t;

    logic [LOG2_N-1:0] cnt;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  total;
    logic              last;
    logic              accept;
    logic              close;
    logic              out_vld;
    result_t           next_res;
    result_t           res;

    // Only the closing sample can stall, and only while the previous result is stuck.
    assign last    = (cnt == LAST);
    assign sum_rdy = !(last && out_vld && !win_rdy);
    assign accept  = sum_vld && sum_rdy && !clr;
    assign close   = accept && last;
    assign total   = acc + ACC_W'(sum_i);

`ifdef SUM_WIN_MAX_EN
    logic [SUM_W-1:0] run_max;
    logic [SUM_W-1:0] max_next;

    assign max_next = (sum_i > run_max) ? sum_i : run_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_max <= '0;
        end else if (clr || close) begin
            run_max <= '0;
        end else if (accept) begin
            run_max <= max_next;
        end
    end
`endif

    always_comb begin
        next_res     = '0;
        next_res.acc = total;
        next_res.avg = SUM_W'(total >> LOG2_N);
`ifdef SUM_WIN_MAX_EN
        next_res.max = max_next;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            acc <= '0;
        end else if (clr) begin
            cnt <= '0;
            acc <= '0;
        end else if (accept) begin
            if (last) begin
                cnt <= '0;
                acc <= '0;
            end else begin
                cnt <= cnt + LOG2_N'(1);
                acc <= total;
            end
        end
    end

    sum_win_outreg #(
        .data_t (result_t)
    ) u_outreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (close),
        .load_data (next_res),
        .out_rdy   (win_rdy),
        .out_vld   (out_vld),
        .out_data  (res)
    );

    assign win_vld = out_vld;
    assign win_acc = res.acc;
    assign win_avg = res.avg;
`ifdef SUM_WIN_MAX_EN
    assign win_max = res.max;
`endif

endmodule
